// File: rtl/adc_apb_sequencer.sv
// adc_apb_sequencer: APB requester that runs one ADC conversion per command and returns the measurement
module adc_apb_sequencer #(
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 12'h000,
  parameter logic [ADDR_WIDTH-1:0] MEAS_ADDR   = 12'h004,
  parameter logic [ADDR_WIDTH-1:0] AMUX_ADDR   = 12'h00C,
  parameter logic [ADDR_WIDTH-1:0] TRIG_ADDR   = 12'h010,
  parameter int                    DONE_BIT    = 0,
  parameter int                    POLL_LIMIT  = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [7:0]            start_chan,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_err,
  output logic                  res_timeout,
  output logic                  busy,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  typedef enum logic [2:0] {IDLE, WR_AMUX, WR_TRIG, RD_STAT, RD_MEAS, RESULT} state_t;
  state_t                state, state_n;
  logic [PW-1:0]         poll_cnt, poll_n, poll_inc;
  logic [7:0]            chan, chan_n;
  logic                  psel_n, penable_n, pwrite_n, xfer_done;
  logic [ADDR_WIDTH-1:0] paddr_n;
  logic [DATA_WIDTH-1:0] pwdata_n, res_data_n;
  logic                  res_valid_n, res_err_n, res_timeout_n;
  assign start_ready = state == IDLE;
  assign busy        = ~start_ready;
  assign xfer_done   = PSEL & PENABLE & PREADY;
  assign poll_inc    = poll_cnt + PW'(1);
  // Next state and next bus/result values; bus fields derive from the state being entered so they stay stable across SETUP and ACCESS
  always_comb begin
    state_n       = state;
    poll_n        = poll_cnt;
    chan_n        = chan;
    res_valid_n   = res_valid;
    res_data_n    = res_data;
    res_err_n     = res_err;
    res_timeout_n = res_timeout;
    if (state == IDLE && start_valid) begin
      state_n = WR_AMUX;
      chan_n  = start_chan;
      poll_n  = '0;
    end else if (state == RESULT && res_ready) begin
      state_n       = IDLE;
      res_valid_n   = 1'b0;
      res_data_n    = '0;
      res_err_n     = 1'b0;
      res_timeout_n = 1'b0;
    end else if (xfer_done && PSLVERR) begin
      state_n     = RESULT;
      res_valid_n = 1'b1;
      res_err_n   = 1'b1;
      res_data_n  = '0;
    end else if (xfer_done) begin
      case (state)
        WR_AMUX: state_n = WR_TRIG;
        WR_TRIG: state_n = RD_STAT;
        RD_STAT: begin
          poll_n = poll_inc;
          if (PRDATA[DONE_BIT]) state_n = RD_MEAS;
          else if (poll_inc == PW'(POLL_LIMIT)) begin
            state_n       = RESULT;
            res_valid_n   = 1'b1;
            res_timeout_n = 1'b1;
            res_data_n    = '0;
          end
        end
        RD_MEAS: begin
          state_n     = RESULT;
          res_valid_n = 1'b1;
          res_data_n  = PRDATA;
        end
        default: ;
      endcase
    end
    psel_n    = state_n inside {WR_AMUX, WR_TRIG, RD_STAT, RD_MEAS};
    penable_n = PSEL & ~xfer_done;
    pwrite_n  = state_n == WR_AMUX || state_n == WR_TRIG;
    paddr_n   = state_n == WR_AMUX ? AMUX_ADDR :
                state_n == WR_TRIG ? TRIG_ADDR :
                state_n == RD_STAT ? STATUS_ADDR :
                state_n == RD_MEAS ? MEAS_ADDR : '0;
    pwdata_n  = state_n == WR_AMUX ? DATA_WIDTH'(chan_n) :
                state_n == WR_TRIG ? DATA_WIDTH'(1) : '0;
  end
  // State, bus and result registers with synchronous active-low reset
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state       <= IDLE;
      poll_cnt    <= '0;
      chan        <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_err     <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      poll_cnt    <= poll_n;
      chan        <= chan_n;
      PSEL        <= psel_n;
      PENABLE     <= penable_n;
      PWRITE      <= pwrite_n;
      PADDR       <= paddr_n;
      PWDATA      <= pwdata_n;
      res_valid   <= res_valid_n;
      res_data    <= res_data_n;
      res_err     <= res_err_n;
      res_timeout <= res_timeout_n;
    end
  end
endmodule

// File: tb/tb_adc_apb_sequencer.sv
// tb_adc_apb_sequencer: directed and randomized commands against an APB slave model and a transaction-level reference
module tb_adc_apb_sequencer;
  localparam int POLL = 16;
  typedef struct packed {logic w; logic [11:0] a; logic [31:0] d;} xfer_t;
  logic        PCLK, PRESETn, start_valid, start_ready, res_valid, res_ready, res_err, res_timeout, busy;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [7:0]  start_chan;
  logic [11:0] PADDR;
  logic [31:0] PWDATA, PRDATA, res_data;
  int          checks = 0, errors = 0;
  int          waits_cfg [64];
  int          stat_ndone, err_at, xfer_idx, wait_cnt, stat_reads;
  logic [31:0] meas_val;
  xfer_t       log_q[$], exp_q[$];
  int          exp_lat;
  logic [31:0] exp_data;
  logic        exp_err, exp_to, mon_en = 1'b0, prev_setup = 1'b0;
  xfer_t       setup_x;

  adc_apb_sequencer dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start_valid(start_valid), .start_ready(start_ready),
    .start_chan(start_chan), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .res_timeout(res_timeout), .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave model: per-transfer wait states, STATUS not-done count, MEAS value, optional PSLVERR on one transfer
  assign PREADY  = (xfer_idx < 64) ? (wait_cnt >= waits_cfg[xfer_idx]) : 1'b1;
  assign PSLVERR = (xfer_idx == err_at);
  assign PRDATA  = (PADDR == 12'h000) ? ((stat_ndone < 0 || stat_reads < stat_ndone) ? 32'hFFFF_FFFE : 32'h0000_0003) :
                   (PADDR == 12'h004) ? meas_val : 32'hDEAD_BEEF;

  always @(posedge PCLK) begin
    if (!PRESETn || (start_valid && start_ready)) begin
      xfer_idx   <= 0;
      wait_cnt   <= 0;
      stat_reads <= 0;
      log_q.delete();
    end else if (PSEL && PENABLE) begin
      if (PREADY) begin
        log_q.push_back('{PWRITE, PADDR, PWDATA});
        xfer_idx <= xfer_idx + 1;
        wait_cnt <= 0;
        if (!PWRITE && PADDR == 12'h000) stat_reads <= stat_reads + 1;
      end else wait_cnt <= wait_cnt + 1;
    end
  end

  // Bus protocol watch: single-cycle SETUP, stable fields through ACCESS, quiet bus when unselected
  always @(negedge PCLK) begin
    if (mon_en) begin
      if (PSEL && !PENABLE) begin
        chk("setup_once", {31'b0, prev_setup}, 0);
        setup_x = '{PWRITE, PADDR, PWDATA};
      end else if (PSEL) begin
        chk("hold_pwrite", {31'b0, PWRITE}, {31'b0, setup_x.w});
        chk("hold_paddr", {20'b0, PADDR}, {20'b0, setup_x.a});
        chk("hold_pwdata", PWDATA, setup_x.d);
      end else chk("idle_bus", PWDATA | {19'b0, PENABLE, PWRITE, PADDR}, 0);
      prev_setup = PSEL && !PENABLE;
    end
  end

  task automatic clr_cfg();
    foreach (waits_cfg[i]) waits_cfg[i] = 0;
    stat_ndone = 0;
    meas_val   = 32'h0;
    err_at     = -1;
  endtask

  // Reference: the transfer list, result and cycle count implied by the slave configuration
  task automatic model(input logic [7:0] ch);
    int ns;
    logic to;
    exp_q.delete();
    to = (stat_ndone < 0) || (stat_ndone >= POLL);
    ns = to ? POLL : stat_ndone + 1;
    exp_q.push_back('{1'b1, 12'h00C, {24'h0, ch}});
    exp_q.push_back('{1'b1, 12'h010, 32'h1});
    repeat (ns) exp_q.push_back('{1'b0, 12'h000, 32'h0});
    if (!to) exp_q.push_back('{1'b0, 12'h004, 32'h0});
    exp_err = 1'b0;
    if (err_at >= 0 && err_at < exp_q.size()) begin
      while (exp_q.size() > err_at + 1) void'(exp_q.pop_back());
      exp_err = 1'b1;
      to = 1'b0;
    end
    exp_to   = to;
    exp_data = (exp_err || to) ? 32'h0 : meas_val;
    exp_lat  = 1;
    foreach (exp_q[i]) exp_lat += 2 + waits_cfg[i];
  endtask

  task automatic start(input logic [7:0] ch);
    @(negedge PCLK);
    start_valid = 1'b1;
    start_chan  = ch;
    chk("start_ready_idle", {31'b0, start_ready}, 1);
    @(posedge PCLK);
    #1 start_chan = 8'hEE;
  endtask

  task automatic run_cmd(input logic [7:0] ch, input int rr);
    int n = 0;
    logic got = 1'b0;
    model(ch);
    start(ch);
    while (!got && n < 400) begin
      @(negedge PCLK);
      n++;
      if (res_valid) got = 1'b1;
      else chk("busy_run", {30'b0, start_ready, busy}, 1);
    end
    start_valid = 1'b0;
    chk("res_valid_seen", {31'b0, got}, 1);
    chk("latency", n, exp_lat);
    chk("res_data", res_data, exp_data);
    chk("res_err", {31'b0, res_err}, {31'b0, exp_err});
    chk("res_timeout", {31'b0, res_timeout}, {31'b0, exp_to});
    for (int i = 0; i < rr; i++) begin
      @(negedge PCLK);
      chk("hold_valid", {30'b0, res_valid, start_ready}, 2);
      chk("hold_data", res_data, exp_data);
      chk("hold_flags", {30'b0, res_err, res_timeout}, {30'b0, exp_err, exp_to});
    end
    res_ready = 1'b1;
    @(posedge PCLK);
    #1 res_ready = 1'b0;
    @(negedge PCLK);
    chk("after_handshake", {28'b0, res_valid, res_err, res_timeout, start_ready}, 1);
    chk("n_xfers", 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk("xfer_dir", {31'b0, log_q[i].w}, {31'b0, exp_q[i].w});
      chk("xfer_addr", {20'b0, log_q[i].a}, {20'b0, exp_q[i].a});
      if (exp_q[i].w) chk("xfer_wdata", log_q[i].d, exp_q[i].d);
    end
  endtask

  initial begin
    int n;
    PRESETn = 1'b0; start_valid = 1'b0; start_chan = 8'h0; res_ready = 1'b0;
    clr_cfg();
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_ready_busy", {30'b0, start_ready, busy}, 2);
    chk("rst_bus", {19'b0, PSEL, PENABLE, PWRITE, PADDR} | PWDATA, 0);
    chk("rst_res", {29'b0, res_valid, res_err, res_timeout} | res_data, 0);
    PRESETn = 1'b1;
    mon_en  = 1'b1;
    meas_val = 32'h0000_0ABC;
    run_cmd(8'h05, 0);
    clr_cfg(); stat_ndone = 2; meas_val = 32'h1234_5678;
    run_cmd(8'h3C, 1);
    clr_cfg(); stat_ndone = -1; meas_val = 32'hFFFF_FFFF;
    run_cmd(8'hA5, 2);
    clr_cfg(); err_at = 1; meas_val = 32'h5555_AAAA;
    run_cmd(8'h07, 0);
    clr_cfg(); meas_val = 32'h0000_0123;
    run_cmd(8'h08, 0);
    clr_cfg(); waits_cfg[3] = 3; meas_val = 32'hCAFE_F00D;
    run_cmd(8'hFF, 5);
    clr_cfg(); stat_ndone = 15; meas_val = 32'h0BAD_0BAD;
    run_cmd(8'h10, 0);
    clr_cfg(); stat_ndone = 16; err_at = 3;
    run_cmd(8'h11, 0);
    clr_cfg(); waits_cfg[2] = 3;
    start(8'h22);
    n = 0;
    while (!(PSEL && PENABLE && !PWRITE && PADDR == 12'h000) && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    chk("reached_rd_stat", {31'b0, PSEL && PENABLE && PADDR == 12'h000}, 1);
    PRESETn = 1'b0;
    start_valid = 1'b0;
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    @(negedge PCLK);
    chk("reset_abort", {28'b0, PSEL, PENABLE, res_valid, start_ready}, 1);
    clr_cfg(); meas_val = 32'h0000_0777;
    run_cmd(8'h33, 1);
    for (int k = 0; k < 25; k++) begin
      clr_cfg();
      foreach (waits_cfg[i]) waits_cfg[i] = int'($urandom_range(0, 2));
      stat_ndone = int'($urandom_range(0, 19)) - 1;
      meas_val   = $urandom;
      err_at     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_cmd(8'($urandom), int'($urandom_range(0, 4)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_apb_sequencer.md
Name: adc_apb_sequencer

Overview:
- APB requester (initiator) that drives the ADC APB register block to take one conversion per command.
- Per command: writes AMUX select, writes trigger, polls STATUS until done, reads MEASUREMENT, returns the result over a valid/ready interface.
- Sits between a control FSM/CPU-side request port and the ADC peripheral's APB slave port.

Parameters:
- ADDR_WIDTH, 12, APB address width
- DATA_WIDTH, 32, APB data width
- STATUS_ADDR, 12'h000, status register address (read)
- MEAS_ADDR, 12'h004, measurement register address (read)
- AMUX_ADDR, 12'h00C, AMUX select register address (write)
- TRIG_ADDR, 12'h010, trigger register address (write)
- DONE_BIT, 0, STATUS bit index meaning conversion complete
- POLL_LIMIT, 16, maximum STATUS reads before timeout (>=1)

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  synchronous active-low reset
- start_valid  in  1  command request
- start_ready  out  1  high only in IDLE
- start_chan  in  8  AMUX channel; written zero-extended to DATA_WIDTH
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  DATA_WIDTH  MEASUREMENT value; 0 on error or timeout
- res_err  out  1  PSLVERR seen during the command
- res_timeout  out  1  POLL_LIMIT exhausted
- busy  out  1  high in any state except IDLE
- PSEL  out  1  APB select
- PENABLE  out  1  APB access phase
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Clock and reset: one clock, PCLK; PRESETn is synchronous and active-low.
- Reset: on a PCLK edge with PRESETn=0, state goes to IDLE.
  - Registered outputs (PSEL, PENABLE, PWRITE, PADDR, PWDATA, res_valid, res_data, res_err, res_timeout) become 0.
  - Poll counter and latched channel become 0.
  - start_ready = (state==IDLE); busy = ~start_ready.
  - Reset mid-transfer abandons the transfer with no completion cycle.
- States: IDLE, WR_AMUX, WR_TRIG, RD_STAT, RD_MEAS, RESULT.
  - Each APB state has a SETUP sub-phase (PSEL=1, PENABLE=0) for exactly 1 cycle.
  - It then has an ACCESS sub-phase (PSEL=1, PENABLE=1), held until PREADY=1.
- PADDR, PWRITE and PWDATA are stable from SETUP through the completing ACCESS cycle. All three are 0 when PSEL=0.
- IDLE: when start_valid & start_ready, latch start_chan, clear the poll counter, go to WR_AMUX SETUP next cycle.
- WR_AMUX: PWRITE=1, PADDR=AMUX_ADDR, PWDATA={0,chan}. On completion go to WR_TRIG.
- WR_TRIG: PWRITE=1, PADDR=TRIG_ADDR, PWDATA=1. On completion go to RD_STAT.
- RD_STAT: PWRITE=0, PADDR=STATUS_ADDR. On completion, increment the poll counter, then:
  - PRDATA[DONE_BIT]=1: go to RD_MEAS.
  - Otherwise, counter==POLL_LIMIT: go to RESULT with res_timeout=1, res_data=0.
  - Otherwise: issue another RD_STAT SETUP on the next cycle. Back-to-back is allowed: PSEL stays 1, PENABLE drops to 0.
- RD_MEAS: PWRITE=0, PADDR=MEAS_ADDR. On completion, capture PRDATA into res_data and go to RESULT.
- PSLVERR: sampled only on a completing ACCESS cycle (PSEL & PENABLE & PREADY).
  - If high: abort remaining transfers and go to RESULT with res_err=1, res_data=0.
  - PRDATA from that cycle is ignored.
- RESULT: PSEL=0, res_valid=1.
  - res_data, res_err and res_timeout are held stable until res_valid & res_ready.
  - After the handshake, go to IDLE next cycle; res_valid=0 and res_err/res_timeout are cleared.
- Latency: with PREADY tied 1 and done on the first poll, the start handshake is cycle 0 and res_valid rises at cycle 9.
  - 4 transfers x 2 cycles, plus 1 cycle.
  - Each PREADY wait state adds 1 cycle; each extra poll adds 2.
- start_valid is ignored outside IDLE; no commands are queued.

Test Plan:
- PREADY=1, start_chan=8'h05, slave STATUS=1, MEAS=32'h0000_0ABC -> transfers in order: W 00C=5, W 010=1, R 000, R 004; res_valid at cycle 9, res_data=0xABC, err=0, timeout=0.
- STATUS reads 0 twice then 1 -> exactly 3 STATUS reads; res_valid at cycle 13; PADDR/PWDATA stable through each phase.
- STATUS always 0, POLL_LIMIT=16 -> exactly 16 STATUS reads, no MEAS read, res_timeout=1, res_data=0.
- PSLVERR=1 on WR_TRIG completion -> no reads issued, res_err=1, res_data=0; next command runs normally.
- PREADY low for 3 cycles on the MEAS read; res_ready held low for 5 cycles -> PENABLE held 4 cycles; result held stable; start_ready low until the handshake.
- PRESETn low for one edge during RD_STAT ACCESS -> next cycle PSEL=0, PENABLE=0, res_valid=0, start_ready=1; a new start completes normally.
